// File: rtl/jtag_tap_sampled.sv
// JTAG TAP controller driven by an oversampled tck. It provides the 1149.1 FSM, IR, BYPASS,
// optional IDCODE (enabled by JTAG_TAP_IDCODE_EN) and strobes for one user data register.
module jtag_tap_sampled #(
    parameter int                  IR_WIDTH     = 4,
    parameter logic [31:0]         IDCODE_VALUE = 32'h149511C3,
    parameter logic [IR_WIDTH-1:0] IDCODE_IR    = 'h1,
    parameter logic [IR_WIDTH-1:0] USER_IR      = 'h8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tck,
    input  logic       tms,
    input  logic       tdi,
    output logic       tdo,
    output logic       tdo_oe,
    output logic [3:0] tap_state,
    output logic       user_sel,
    output logic       capture_dr,
    output logic       shift_dr,
    output logic       update_dr,
    output logic       dr_tdi,
    input  logic       user_tdo
);

    typedef enum logic [3:0] {
        TLR      = 4'hF,
        RTI      = 4'hC,
        SEL_DR   = 4'h7,
        CAP_DR   = 4'h6,
        SH_DR    = 4'h2,
        EX1_DR   = 4'h1,
        PAUSE_DR = 4'h3,
        EX2_DR   = 4'h0,
        UPD_DR   = 4'h5,
        SEL_IR   = 4'h4,
        CAP_IR   = 4'hE,
        SH_IR    = 4'hA,
        EX1_IR   = 4'h9,
        PAUSE_IR = 4'hB,
        EX2_IR   = 4'h8,
        UPD_IR   = 4'hD
    } tap_state_e;

`ifdef JTAG_TAP_IDCODE_EN
    localparam logic [IR_WIDTH-1:0] IR_RESET = IDCODE_IR;
`else
    localparam logic [IR_WIDTH-1:0] IR_RESET = '1;
`endif
    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = {{(IR_WIDTH-1){1'b0}}, 1'b1};

    if (IR_WIDTH < 2 || IDCODE_VALUE[0] != 1'b1 || IDCODE_IR == USER_IR) begin : g_param_check
        $error("jtag_tap_sampled: illegal parameter combination");
    end

    // ------------------------------------------------------------------
    // Pin synchronizers; tck gets a third stage so edges are seen once.
    // ------------------------------------------------------------------
    logic [2:0] tck_sync;
    logic [1:0] tms_sync;
    logic [1:0] tdi_sync;
    logic       rise;
    logic       fall;
    logic       tms_s;
    logic       tdi_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tck_sync <= '0;
            tms_sync <= '0;
            tdi_sync <= '0;
        end else begin
            tck_sync <= {tck_sync[1:0], tck};
            tms_sync <= {tms_sync[0], tms};
            tdi_sync <= {tdi_sync[0], tdi};
        end
    end

    assign rise  = tck_sync[1] & ~tck_sync[2];
    assign fall  = ~tck_sync[1] & tck_sync[2];
    assign tms_s = tms_sync[1];
    assign tdi_s = tdi_sync[1];

    // ------------------------------------------------------------------
    // TAP state machine
    // ------------------------------------------------------------------
    tap_state_e state;
    tap_state_e state_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= TLR;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (rise) begin
            case (state)
                TLR:      state_next = tms_s ? TLR    : RTI;
                RTI:      state_next = tms_s ? SEL_DR : RTI;
                SEL_DR:   state_next = tms_s ? SEL_IR : CAP_DR;
                CAP_DR:   state_next = tms_s ? EX1_DR : SH_DR;
                SH_DR:    state_next = tms_s ? EX1_DR : SH_DR;
                EX1_DR:   state_next = tms_s ? UPD_DR : PAUSE_DR;
                PAUSE_DR: state_next = tms_s ? EX2_DR : PAUSE_DR;
                EX2_DR:   state_next = tms_s ? UPD_DR : SH_DR;
                UPD_DR:   state_next = tms_s ? SEL_DR : RTI;
                SEL_IR:   state_next = tms_s ? TLR    : CAP_IR;
                CAP_IR:   state_next = tms_s ? EX1_IR : SH_IR;
                SH_IR:    state_next = tms_s ? EX1_IR : SH_IR;
                EX1_IR:   state_next = tms_s ? UPD_IR : PAUSE_IR;
                PAUSE_IR: state_next = tms_s ? EX2_IR : PAUSE_IR;
                EX2_IR:   state_next = tms_s ? UPD_IR : SH_IR;
                UPD_IR:   state_next = tms_s ? SEL_DR : RTI;
                default:  state_next = TLR;
            endcase
        end
    end

    assign tap_state = state;

    logic in_shift;
    assign in_shift = (state == SH_DR) || (state == SH_IR);

    // ------------------------------------------------------------------
    // Instruction register
    // ------------------------------------------------------------------
    logic [IR_WIDTH-1:0] ir_sr;
    logic [IR_WIDTH-1:0] ir;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir_sr <= IR_CAPTURE;
            ir    <= IR_RESET;
        end else begin
            if (rise && state == CAP_IR) begin
                ir_sr <= IR_CAPTURE;
            end else if (rise && state == SH_IR) begin
                ir_sr <= {tdi_s, ir_sr[IR_WIDTH-1:1]};
            end
            if (state == TLR) begin
                ir <= IR_RESET;
            end else if (fall && state == UPD_IR) begin
                ir <= ir_sr;
            end
        end
    end

    // ------------------------------------------------------------------
    // Data register selection and the internal data registers
    // ------------------------------------------------------------------
    logic sel_bypass;
    logic bypass_sr;
    logic shift_lsb;

    assign user_sel = (ir == USER_IR);

`ifdef JTAG_TAP_IDCODE_EN
    logic        sel_idcode;
    logic [31:0] idcode_sr;

    assign sel_idcode = ~user_sel & (ir == IDCODE_IR);
    assign sel_bypass = ~user_sel & ~sel_idcode;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idcode_sr <= IDCODE_VALUE;
        end else if (rise && sel_idcode) begin
            if (state == CAP_DR) begin
                idcode_sr <= IDCODE_VALUE;
            end else if (state == SH_DR) begin
                idcode_sr <= {tdi_s, idcode_sr[31:1]};
            end
        end
    end
`else
    assign sel_bypass = ~user_sel;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bypass_sr <= 1'b0;
        end else if (rise && sel_bypass) begin
            if (state == CAP_DR) begin
                bypass_sr <= 1'b0;
            end else if (state == SH_DR) begin
                bypass_sr <= tdi_s;
            end
        end
    end

    // IR scans always drive the IR LSB; DR scans use whichever register is selected.
    always_comb begin
        shift_lsb = bypass_sr;
        if (state == SH_IR) begin
            shift_lsb = ir_sr[0];
        end else if (user_sel) begin
            shift_lsb = user_tdo;
`ifdef JTAG_TAP_IDCODE_EN
        end else if (sel_idcode) begin
            shift_lsb = idcode_sr[0];
`endif
        end
    end

    // ------------------------------------------------------------------
    // Serial output, registered on the falling tck edge
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tdo    <= 1'b0;
            tdo_oe <= 1'b0;
        end else if (fall) begin
            tdo_oe <= in_shift;
            if (in_shift) begin
                tdo <= shift_lsb;
            end
        end
    end

    // ------------------------------------------------------------------
    // User data-register strobes: one clk wide, one per qualifying edge
    // ------------------------------------------------------------------
    logic shift_hit;
    assign shift_hit = rise && (state == SH_DR) && user_sel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            capture_dr <= 1'b0;
            shift_dr   <= 1'b0;
            update_dr  <= 1'b0;
            dr_tdi     <= 1'b0;
        end else begin
            capture_dr <= rise && (state == CAP_DR) && user_sel;
            shift_dr   <= shift_hit;
            update_dr  <= fall && (state == UPD_DR) && user_sel;
            if (shift_hit) begin
                dr_tdi <= tdi_s;
            end
        end
    end

endmodule
